// File: rtl/lc4_nzp_branch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lc4_nzp_branch_unit: NZP flag register and BR resolver with a one-entry   |
// | output buffer. Optional LC4_NZP_BYPASS_EN forwards same-cycle results.    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module lc4_nzp_branch_unit #(
  parameter int ADDR_W = 16,
  parameter int OFF_W  = 9,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gwe,
  input  logic              wr_valid,
  input  logic [15:0]       wr_data,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [2:0]        br_mask,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [OFF_W-1:0]  br_off,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_taken,
  output logic [ADDR_W-1:0] out_target,
  output logic [2:0]        nzp,
  output logic [CNT_W-1:0]  br_count,
  output logic [CNT_W-1:0]  taken_count
);

  localparam logic [CNT_W-1:0]  c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] c_addr_one = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [2:0]          r_nzp;
  logic                r_taken;
  logic [ADDR_W-1:0]   r_target;
  logic [CNT_W-1:0]    r_br_count;
  logic [CNT_W-1:0]    r_taken_count;

  logic [2:0]          w_decode;
  logic [2:0]          w_flags_eff;
  logic                w_stall;
  logic                w_accept;
  logic                w_taken;
  logic [ADDR_W-1:0]   w_off_ext;
  logic [ADDR_W-1:0]   w_pc_inc;
  logic [ADDR_W-1:0]   w_target;

  assign w_decode = {wr_data[15],
                     (wr_data == 16'h0000),
                     (!wr_data[15] && (wr_data != 16'h0000))};

`ifdef LC4_NZP_BYPASS_EN
  // A result written in the same cycle is older than the branch, so forward it.
  assign w_flags_eff = wr_valid ? w_decode : r_nzp;
  assign w_stall     = 1'b0;
`else
  assign w_flags_eff = r_nzp;
  assign w_stall     = wr_valid;
`endif

  assign out_valid = (r_state == FULL);
  assign br_ready  = (!out_valid || out_ready) && !w_stall;
  assign w_accept  = gwe && br_valid && br_ready;

  assign w_taken   = |(br_mask & w_flags_eff);
  assign w_off_ext = {{(ADDR_W-OFF_W){br_off[OFF_W-1]}}, br_off};
  assign w_pc_inc  = br_pc + c_addr_one;
  assign w_target  = w_taken ? (w_pc_inc + w_off_ext) : w_pc_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (gwe) begin
      case (r_state)
        EMPTY:   if (w_accept) w_state_next = FULL;
        FULL:    if (out_ready) w_state_next = w_accept ? FULL : EMPTY;
        default: w_state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_nzp         <= 3'b010;
      r_taken       <= 1'b0;
      r_target      <= '0;
      r_br_count    <= '0;
      r_taken_count <= '0;
    end else if (gwe) begin
      if (wr_valid) begin
        r_nzp <= w_decode;
      end
      if (w_accept) begin
        r_taken  <= w_taken;
        r_target <= w_target;
        // Statistics saturate rather than wrap.
        if (r_br_count != {CNT_W{1'b1}}) begin
          r_br_count <= r_br_count + c_cnt_one;
        end
        if (w_taken && (r_taken_count != {CNT_W{1'b1}})) begin
          r_taken_count <= r_taken_count + c_cnt_one;
        end
      end
    end
  end

  assign nzp         = r_nzp;
  assign out_taken   = r_taken;
  assign out_target  = r_target;
  assign br_count    = r_br_count;
  assign taken_count = r_taken_count;

endmodule
`default_nettype wire

// File: tb/tb_lc4_nzp_branch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lc4_nzp_branch_unit: directed bench with a queue-based reference model.|
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_lc4_nzp_branch_unit;

  logic        clk = 1'b0;
  logic        rst, gwe, wr_valid, br_valid, out_ready;
  logic [15:0] wr_data, br_pc;
  logic [2:0]  br_mask;
  logic [8:0]  br_off;
  logic        br_ready, out_valid, out_taken;
  logic [15:0] out_target, br_count, taken_count;
  logic [2:0]  nzp;

  int n_vec = 0;
  int n_bad = 0;

  lc4_nzp_branch_unit dut (
    .clk(clk), .rst(rst), .gwe(gwe),
    .wr_valid(wr_valid), .wr_data(wr_data),
    .br_valid(br_valid), .br_ready(br_ready),
    .br_mask(br_mask), .br_pc(br_pc), .br_off(br_off),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_taken(out_taken), .out_target(out_target),
    .nzp(nzp), .br_count(br_count), .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: flags as a signed classification, outputs as a queue.
  int  m_q[$];
  int  m_nzp, m_brc, m_tkc;
  bit  chk_en = 0;

  function automatic int classify(input logic [15:0] d);
    int v;
    v = d[15] ? int'(d) - 65536 : int'(d);
    if (v < 0) return 4;
    if (v == 0) return 2;
    return 1;
  endfunction

  function automatic bit model_ready();
`ifdef LC4_NZP_BYPASS_EN
    return (m_q.size() == 0) || out_ready;
`else
    return ((m_q.size() == 0) || out_ready) && !wr_valid;
`endif
  endfunction

  always @(posedge clk) begin
    int  eff, offv, tgt;
    bit  rdy, tk;
    if (rst) begin
      m_q.delete();
      m_nzp  = 2;
      m_brc  = 0;
      m_tkc  = 0;
      chk_en = 1;
    end else if (gwe) begin
      rdy = model_ready();
      if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
      if (br_valid && rdy) begin
`ifdef LC4_NZP_BYPASS_EN
        eff = wr_valid ? classify(wr_data) : m_nzp;
`else
        eff = m_nzp;
`endif
        tk   = (int'(br_mask) & eff) != 0;
        offv = br_off[8] ? int'(br_off) - 512 : int'(br_off);
        tgt  = (int'(br_pc) + 1 + (tk ? offv : 0)) & 16'hFFFF;
        m_q.push_back((tk ? 65536 : 0) + tgt);
        if (m_brc < 65535) m_brc++;
        if (tk && m_tkc < 65535) m_tkc++;
      end
      if (wr_valid) m_nzp = classify(wr_data);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", {31'd0, out_valid}, {31'd0, m_q.size() != 0});
      if (m_q.size() != 0) begin
        check("out_taken", {31'd0, out_taken}, (m_q[0] >> 16) & 1);
        check("out_target", {16'd0, out_target}, m_q[0] & 16'hFFFF);
      end
      check("nzp", {29'd0, nzp}, m_nzp);
      check("br_count", {16'd0, br_count}, m_brc);
      check("taken_count", {16'd0, taken_count}, m_tkc);
      check("br_ready", {31'd0, br_ready}, {31'd0, model_ready()});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_br(input logic [2:0] m, input logic [15:0] pc, input logic [8:0] off);
    br_valid = 1'b1; br_mask = m; br_pc = pc; br_off = off;
  endtask

  initial begin
    rst = 1'b1; gwe = 1'b1; wr_valid = 1'b0; wr_data = '0;
    br_valid = 1'b0; br_mask = '0; br_pc = '0; br_off = '0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    check("rst_nzp", {29'd0, nzp}, 32'h2);
    check("rst_valid", {31'd0, out_valid}, 32'h0);
    check("rst_target", {16'd0, out_target}, 32'h0);
    check("rst_count", {16'd0, br_count}, 32'h0);

    // Basic taken branch on reset flags
    set_br(3'b010, 16'h0010, 9'h005);
    #1 check("t1_ready", {31'd0, br_ready}, 32'h1);
    step(); br_valid = 1'b0;
    check("t1_valid", {31'd0, out_valid}, 32'h1);
    check("t1_taken", {31'd0, out_taken}, 32'h1);
    check("t1_target", {16'd0, out_target}, 32'h0016);

    // Negative result then backward branch
    wr_valid = 1'b1; wr_data = 16'hFFFF;
    step(); wr_valid = 1'b0;
    check("t2_nzp", {29'd0, nzp}, 32'h4);
    set_br(3'b100, 16'h0100, 9'h1FE);
    step(); br_valid = 1'b0;
    check("t2_taken", {31'd0, out_taken}, 32'h1);
    check("t2_target", {16'd0, out_target}, 32'h00FF);

    // Same-cycle write and branch
    wr_valid = 1'b1; wr_data = 16'h0001;
    set_br(3'b001, 16'h0020, 9'h000);
`ifdef LC4_NZP_BYPASS_EN
    #1 check("t3_ready", {31'd0, br_ready}, 32'h1);
    step(); wr_valid = 1'b0; br_valid = 1'b0;
`else
    #1 check("t3_ready", {31'd0, br_ready}, 32'h0);
    step(); wr_valid = 1'b0;
    check("t3_nzp", {29'd0, nzp}, 32'h1);
    step(); br_valid = 1'b0;
`endif
    check("t3_taken", {31'd0, out_taken}, 32'h1);
    check("t3_target", {16'd0, out_target}, 32'h0021);
    step();

    // Backpressure, then back-to-back drain
    out_ready = 1'b0;
    set_br(3'b111, 16'h0040, 9'h003);
    step();
    check("t4_target", {16'd0, out_target}, 32'h0044);
    check("t4_count", {16'd0, br_count}, 32'd4);
    for (int i = 0; i < 3; i++) begin
      #1 check("t4_hold_ready", {31'd0, br_ready}, 32'h0);
      step();
      check("t4_hold_target", {16'd0, out_target}, 32'h0044);
      check("t4_hold_count", {16'd0, br_count}, 32'd4);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_br(3'b111, 16'h0050 + 16'(i * 16), 9'h003);
      step();
      check("t4_b2b_target", {16'd0, out_target}, 32'h0054 + i * 16);
      check("t4_b2b_count", {16'd0, br_count}, 32'd5 + i);
    end
    br_valid = 1'b0;
    step();

    // Empty mask with PC wrap, then frozen by gwe
    set_br(3'b000, 16'hFFFF, 9'h00F);
    step(); br_valid = 1'b0;
    check("t5_taken", {31'd0, out_taken}, 32'h0);
    check("t5_target", {16'd0, out_target}, 32'h0000);
    check("t5_tkcount", {16'd0, taken_count}, 32'd7);
    step();
    gwe = 1'b0; wr_valid = 1'b1; wr_data = 16'h0000;
    set_br(3'b111, 16'h0200, 9'h001);
    step(); step();
    check("t5_gwe_nzp", {29'd0, nzp}, 32'h1);
    check("t5_gwe_count", {16'd0, br_count}, 32'd8);
    check("t5_gwe_valid", {31'd0, out_valid}, 32'h0);
    gwe = 1'b1; wr_valid = 1'b0; br_valid = 1'b0;
    step();

    // Reset while FULL
    out_ready = 1'b0;
    set_br(3'b010, 16'h0300, 9'h001);
    step(); br_valid = 1'b0;
    check("t6_full", {31'd0, out_valid}, 32'h1);
    rst = 1'b1;
    step(); rst = 1'b0;
    check("t6_valid", {31'd0, out_valid}, 32'h0);
    check("t6_nzp", {29'd0, nzp}, 32'h2);
    check("t6_count", {16'd0, br_count}, 32'h0);
    check("t6_tkcount", {16'd0, taken_count}, 32'h0);
    out_ready = 1'b1;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
